down_timer: RTL and testbench
=============================

Name: down_timer

Overview:
- Loadable, prescaled down-counter. It is the counting-down counterpart of the free-running up-counter already in the Lab1 datapath.
- Accepts a start value over a valid/ready load handshake, then decrements once per prescaled step. It flags terminal count and optionally auto-reloads.
- Drives the display/Vbuddy path as a countdown timer, and drives one-shot delays for other lab blocks.

Parameters:
- WIDTH, 8, width of count value and load value
- PW, 16, width of the prescale input and internal prescale counter

Ports:
- clk  in  1  clock
- rst  in  1  reset
- load_valid  in  1  load request; load_value is valid while high
- load_ready  out  1  block can accept a load this cycle
- load_value  in  WIDTH  start value for countdown
- prescale  in  PW  step period minus one, in enabled clk cycles (0 = step every enabled cycle)
- en  in  1  step enable; low freezes count and prescaler
- auto_reload  in  1  at terminal count, reload the last loaded value and keep running
- abort  in  1  stop a running countdown
- count  out  WIDTH  current count value
- busy  out  1  high in RUN
- done  out  1  high in DONE (countdown finished, not reloading)
- tc  out  1  one-cycle terminal-count pulse

Behaviour:
- Reset: rst, synchronous, active-high; clock clk. All state updates on posedge clk.
- Reset values: state IDLE, count=0, reload_reg=0, presc_cnt=0, busy=0, done=0, tc=0, load_ready=1. rst overrides every other input, including mid-run.
- FSM states are IDLE, RUN and DONE. Outputs decode from registered state: busy = (state==RUN), done = (state==DONE), load_ready = (state!=RUN).
- Load accept: load_valid && load_ready at a posedge.
  - On accept: count<=load_value, reload_reg<=load_value, presc_cnt<=0.
  - load_value != 0: state<=RUN.
  - load_value == 0: state<=DONE and tc<=1 for one cycle.
  - Accept is legal from IDLE and DONE.
  - load_valid in RUN is ignored; the source must hold it until load_ready is high.
- Step strobe, RUN only: step = en && (presc_cnt >= prescale).
  - The >= compare makes a mid-run decrease of prescale take effect without wrap.
  - On step, presc_cnt<=0. Otherwise, if en, presc_cnt<=presc_cnt+1. If !en, presc_cnt holds.
  - presc_cnt is held at 0 outside RUN.
- Decrement, on step in RUN:
  - count > 1: count<=count-1.
  - count == 1 and auto_reload=1: count<=reload_reg, tc<=1, stay in RUN. count never shows 0 in this mode.
  - count == 1 and auto_reload=0: count<=0, tc<=1, state<=DONE.
  - auto_reload is sampled only on the terminal step.
- tc is registered and high exactly one cycle after each terminal step, or after a zero-load. It is low at all other times.
- abort:
  - In RUN: state<=IDLE, count<=0, presc_cnt<=0, no tc. abort takes priority over a coincident step.
  - In IDLE and DONE, abort is ignored.
  - If abort and load_valid are both high in DONE, the load is accepted.
- Arithmetic: count is unsigned modulo 2^WIDTH, but never decrements below 0 because the terminal step is intercepted at 1. Max load 2^WIDTH-1 gives 2^WIDTH-1 steps.
- Latency: the first decrement occurs (prescale+1) enabled cycles after the accept edge. The terminal step for load value N occurs N*(prescale+1) enabled cycles after accept.
- DONE holds count=0 and done=1 until the next accepted load or rst.

Test Plan:
- Reset: rst high 2 cycles mid-RUN (count=5) -> next cycle count=0, busy=0, done=0, tc=0, load_ready=1.
- Basic countdown: prescale=0, en=1, load 3 -> count 3,2,1,0 on successive edges. tc high one cycle coincident with count=0, then done=1, busy=0, load_ready=1.
- Prescale and enable:
  - prescale=2, load 2, en=1 -> count decrements every 3 cycles. tc is 6 cycles after accept.
  - Same, with en low for 4 cycles mid-run -> tc is delayed exactly 4 cycles and count holds while en is low.
- Auto-reload: prescale=0, auto_reload=1, load 2 -> count 2,1,2,1,... with a tc pulse each time 1->2. Dropping auto_reload -> next terminal gives count=0, DONE.
- Handshake and boundaries:
  - load_valid held during RUN -> not accepted until DONE, then count=new value the next cycle.
  - Load 0 -> DONE plus one tc pulse.
  - Load 255 (WIDTH=8) -> exactly 255 steps.
- Abort: abort during RUN coincident with a step at count=1 -> IDLE, count=0, no tc. abort in DONE -> no state change.

Source files
------------

// File: rtl/down_timer.sv
// Loadable, prescaled down-counter with valid/ready load, terminal-count pulse
// and optional auto-reload of the last loaded value.
module down_timer #(
   parameter int WIDTH = 8,
   parameter int PW    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_value,
   input  logic [PW-1:0]    prescale,
   input  logic             en,
   input  logic             auto_reload,
   input  logic             abort,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             tc
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] count_n, reload_reg, reload_n;
   logic [PW-1:0]    presc_cnt, presc_n;
   logic             tc_n, step;

   // >= rather than == so lowering prescale mid-run cannot strand the counter
   assign step = en && (presc_cnt >= prescale);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         count      <= '0;
         reload_reg <= '0;
         presc_cnt  <= '0;
         tc         <= 1'b0;
      end else begin
         state      <= state_n;
         count      <= count_n;
         reload_reg <= reload_n;
         presc_cnt  <= presc_n;
         tc         <= tc_n;
      end
   end

   always_comb begin
      state_n  = state;
      count_n  = count;
      reload_n = reload_reg;
      presc_n  = presc_cnt;
      tc_n     = 1'b0;
      case (state)
         RUN: begin
            if (abort) begin
               state_n = IDLE;
               count_n = '0;
               presc_n = '0;
            end else if (step) begin
               presc_n = '0;
               if (count > WIDTH'(1)) begin
                  count_n = count - WIDTH'(1);
               end else if (auto_reload) begin
                  count_n = reload_reg;
                  tc_n    = 1'b1;
               end else begin
                  count_n = '0;
                  tc_n    = 1'b1;
                  state_n = DONE;
               end
            end else if (en) begin
               presc_n = presc_cnt + PW'(1);
            end
         end
         default: begin
            // IDLE and DONE: abort is ignored, a load is always accepted
            presc_n = '0;
            if (load_valid) begin
               count_n  = load_value;
               reload_n = load_value;
               if (load_value != '0) begin
                  state_n = RUN;
               end else begin
                  state_n = DONE;
                  tc_n    = 1'b1;
               end
            end
         end
      endcase
   end

   assign busy       = (state == RUN);
   assign done       = (state == DONE);
   assign load_ready = (state != RUN);

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer: vector table plus multi-cycle sequences.
module tb_down_timer;

   logic       clk = 1'b0;
   logic       rst, load_valid, load_ready, en, auto_reload, abort;
   logic [7:0] load_value, count;
   logic [15:0] prescale;
   logic       busy, done, tc;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   down_timer #(.WIDTH(8), .PW(16)) dut (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
      .load_value(load_value), .prescale(prescale), .en(en),
      .auto_reload(auto_reload), .abort(abort), .count(count),
      .busy(busy), .done(done), .tc(tc)
   );

   typedef struct {
      logic       rst, lv;
      logic [7:0] lval;
      logic       en, ar, ab;
      logic [7:0] c;
      logic       busy, done, tc, rdy;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // inputs are changed 1 time unit after a posedge and outputs are sampled there
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rst = 0; load_valid = 0; load_value = 0; en = 1; auto_reload = 0; abort = 0;
   endtask

   initial begin
      int tc_at;
      int steps;
      idle_inputs();
      prescale = 0;

      //             rst lv lval en ar ab  cnt busy done tc rdy
      vecs.push_back('{1, 0, 0,   1, 0, 0,  0,  0,   0,  0, 1}); // reset
      vecs.push_back('{1, 0, 0,   1, 0, 0,  0,  0,   0,  0, 1});
      vecs.push_back('{0, 1, 3,   1, 0, 0,  3,  1,   0,  0, 0}); // basic countdown
      vecs.push_back('{0, 0, 0,   1, 0, 0,  2,  1,   0,  0, 0});
      vecs.push_back('{0, 0, 0,   1, 0, 0,  1,  1,   0,  0, 0});
      vecs.push_back('{0, 0, 0,   1, 0, 0,  0,  0,   1,  1, 1});
      vecs.push_back('{0, 0, 0,   1, 0, 0,  0,  0,   1,  0, 1});
      vecs.push_back('{0, 1, 0,   1, 0, 0,  0,  0,   1,  1, 1}); // zero load
      vecs.push_back('{0, 0, 0,   1, 0, 0,  0,  0,   1,  0, 1});
      vecs.push_back('{0, 0, 0,   1, 0, 1,  0,  0,   1,  0, 1}); // abort in DONE
      vecs.push_back('{0, 1, 2,   1, 1, 1,  2,  1,   0,  0, 0}); // load wins over abort
      vecs.push_back('{0, 0, 0,   1, 1, 0,  1,  1,   0,  0, 0}); // auto-reload
      vecs.push_back('{0, 0, 0,   1, 1, 0,  2,  1,   0,  1, 0});
      vecs.push_back('{0, 0, 0,   1, 1, 0,  1,  1,   0,  0, 0});
      vecs.push_back('{0, 0, 0,   1, 1, 0,  2,  1,   0,  1, 0});
      vecs.push_back('{0, 0, 0,   1, 0, 0,  1,  1,   0,  0, 0}); // drop auto_reload
      vecs.push_back('{0, 0, 0,   1, 0, 0,  0,  0,   1,  1, 1});
      vecs.push_back('{0, 1, 5,   1, 0, 0,  5,  1,   0,  0, 0}); // reset mid-run
      vecs.push_back('{1, 0, 0,   1, 0, 0,  0,  0,   0,  0, 1});
      vecs.push_back('{1, 0, 0,   1, 0, 0,  0,  0,   0,  0, 1});
      vecs.push_back('{0, 1, 2,   1, 0, 0,  2,  1,   0,  0, 0}); // abort vs step at 1
      vecs.push_back('{0, 0, 0,   1, 0, 0,  1,  1,   0,  0, 0});
      vecs.push_back('{0, 0, 0,   1, 0, 1,  0,  0,   0,  0, 1});
      vecs.push_back('{0, 0, 0,   1, 0, 0,  0,  0,   0,  0, 1});
      vecs.push_back('{0, 1, 4,   1, 0, 0,  4,  1,   0,  0, 0}); // en gap
      vecs.push_back('{0, 0, 0,   0, 0, 0,  4,  1,   0,  0, 0});
      vecs.push_back('{0, 0, 0,   1, 0, 0,  3,  1,   0,  0, 0});
      vecs.push_back('{0, 1, 9,   1, 0, 0,  2,  1,   0,  0, 0}); // held load in RUN
      vecs.push_back('{0, 1, 9,   1, 0, 0,  1,  1,   0,  0, 0});
      vecs.push_back('{0, 1, 9,   1, 0, 0,  0,  0,   1,  1, 1});
      vecs.push_back('{0, 1, 9,   1, 0, 0,  9,  1,   0,  0, 0});
      vecs.push_back('{0, 0, 0,   1, 0, 1,  0,  0,   0,  0, 1});

      foreach (vecs[i]) begin
         rst = vecs[i].rst; load_valid = vecs[i].lv; load_value = vecs[i].lval;
         en = vecs[i].en; auto_reload = vecs[i].ar; abort = vecs[i].ab;
         tick();
         chk($sformatf("v%0d count", i), count, vecs[i].c);
         chk($sformatf("v%0d busy", i), busy, vecs[i].busy);
         chk($sformatf("v%0d done", i), done, vecs[i].done);
         chk($sformatf("v%0d tc", i), tc, vecs[i].tc);
         chk($sformatf("v%0d load_ready", i), load_ready, vecs[i].rdy);
      end

      // prescale=2, load 2: step every 3 cycles, tc after 6
      idle_inputs();
      prescale = 2;
      load_valid = 1; load_value = 2;
      tick();
      load_valid = 0;
      tc_at = -1;
      for (int t = 1; t <= 20 && tc_at < 0; t++) begin
         tick();
         if (t == 2) chk("presc count@2", count, 2);
         if (t == 3) chk("presc count@3", count, 1);
         if (tc) tc_at = t;
      end
      chk("presc tc latency", tc_at, 6);
      chk("presc done", done, 1);

      // same, en low for 4 cycles mid-run: tc slips by exactly 4
      load_valid = 1; load_value = 2;
      tick();
      load_valid = 0;
      tc_at = -1;
      for (int t = 1; t <= 30 && tc_at < 0; t++) begin
         en = !(t >= 3 && t <= 6);
         tick();
         if (t == 6) chk("en-gap count held", count, 2);
         if (tc) tc_at = t;
      end
      chk("en-gap tc latency", tc_at, 10);
      en = 1;

      // max load: 255 steps at prescale 0
      prescale = 0;
      load_valid = 1; load_value = 8'd255;
      tick();
      load_valid = 0;
      chk("max load count", count, 255);
      steps = -1;
      for (int t = 1; t <= 400 && steps < 0; t++) begin
         tick();
         if (tc) steps = t;
      end
      chk("max load steps", steps, 255);
      chk("max load final count", count, 0);
      tick();
      chk("max load tc single", tc, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
